// File: rtl/dff_pipe_async_rst.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshake, bubble collapse,
// synchronous flush and asynchronous active-low reset. Optional occupancy counter: DFF_PIPE_OCC_COUNT_EN.
module dff_pipe_async_rst #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef DFF_PIPE_OCC_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];

  // A stage advances when it is valid and either some stage above it is empty
  // or the output is being consumed; this flattens the recursive ready chain.
  always_comb begin
    logic full_above;
    full_above = 1'b1;
    adv        = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i]     = v_q[i] & (~full_above | out_ready);
      full_above = full_above & v_q[i];
    end
  end

  assign in_ready = ~flush & (~v_q[0] | adv[0]);

  always_comb begin
    load    = '0;
    load[0] = in_valid & in_ready;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = adv[i-1];
    end
  end

  always_comb begin
    v_d    = flush ? '0 : (load | (v_q & ~adv));
    d_d[0] = (load[0] & ~flush) ? in_data : d_q[0];
    for (int i = 1; i < DEPTH; i++) begin
      d_d[i] = (load[i] & ~flush) ? d_q[i-1] : d_q[i];
    end
  end

  // stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= RST_VAL;
      end
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

`ifdef DFF_PIPE_OCC_COUNT_EN
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             push;
  logic             pop;

  assign push = load[0];
  assign pop  = adv[DEPTH-1];

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;
`endif

endmodule
